mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter_pkg.sv | 42 ++++
 rtl/mem_net_buf.sv | 57 +++++
 rtl/mem_req_arbiter.sv | 74 +++++++
 tb/tb_mem_req_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-network types: request/response message layouts and the origin field width.
package mem_req_arbiter_pkg;

    localparam int unsigned ORIGIN_W = 2;

    typedef enum logic [2:0] {
        MEM_REQ_READ    = 3'd0,
        MEM_REQ_WRITE   = 3'd1,
        MEM_REQ_AMO_ADD = 3'd2,
        MEM_REQ_INIT    = 3'd3
    } mem_net_req_type_e;

    typedef struct packed {
        mem_net_req_type_e    kind;
        logic [7:0]           opaque;
        logic [ORIGIN_W-1:0]  origin;
        logic [31:0]          addr;
        logic [1:0]           len;
        logic [31:0]          data;
    } mem_net_req_msg_t;

    typedef struct packed {
        mem_net_req_type_e    kind;
        logic [7:0]           opaque;
        logic [ORIGIN_W-1:0]  origin;
        logic [1:0]           test;
        logic [1:0]           len;
        logic [31:0]          data;
    } mem_net_resp_msg_t;

    localparam int unsigned REQ_MSG_W  = $bits(mem_net_req_msg_t);
    localparam int unsigned RESP_MSG_W = $bits(mem_net_resp_msg_t);

    function automatic mem_net_req_msg_t stamp_origin(mem_net_req_msg_t msg,
                                                      logic [ORIGIN_W-1:0] origin);
        mem_net_req_msg_t m;
        m        = msg;
        m.origin = origin;
        return m;
    endfunction

endpackage

// File: rtl/mem_net_buf.sv
// Parameterized-depth val/rdy FIFO for memory-network messages; enq_rdy is registered-only.
module mem_net_buf
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned p_depth = 2,
    parameter int unsigned p_width = REQ_MSG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_msg
);

    localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CW = $clog2(p_depth + 1);

    logic [p_width-1:0] entries [p_depth];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;

    assign enq_rdy = (count != CW'(p_depth));
    assign deq_val = (count != '0);
    assign deq_msg = entries[rd_ptr];
    assign push    = enq_val && enq_rdy;
    assign pop     = deq_val && deq_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(p_depth - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PW'(p_depth - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            entries[wr_ptr] <= enq_msg;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of client memory requests onto one port, stamping origin with the winner index.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned p_num_req = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [p_num_req-1:0]           req_val,
    output logic [p_num_req-1:0]           req_rdy,
    input  logic [p_num_req*REQ_MSG_W-1:0] req_msg,
    output logic                           mem_val,
    input  logic                           mem_rdy,
    output logic [REQ_MSG_W-1:0]           mem_msg
);

    localparam int unsigned p_buf_depth = 2;
    localparam int unsigned PTR_W = (p_num_req > 1) ? $clog2(p_num_req) : 1;

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     win;
    logic [PTR_W-1:0]     idx;
    logic                 found;
    logic                 accept;
    logic                 buf_rdy;
    mem_net_req_msg_t     push_msg;

    // Rotate-and-priority-encode: first valid port scanning upward from ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < p_num_req; k++) begin
            idx = PTR_W'((32'(ptr) + k) % p_num_req);
            if (!found && req_val[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Gating with rst keeps every rdy low while reset is held, with count already zero.
    assign accept   = found && buf_rdy && rst;
    assign push_msg = stamp_origin(mem_net_req_msg_t'(req_msg[32'(win)*REQ_MSG_W +: REQ_MSG_W]),
                                   ORIGIN_W'(win));

    always_comb begin
        req_rdy = '0;
        if (accept)
            req_rdy[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (accept)
            ptr <= (win == PTR_W'(p_num_req - 1)) ? '0 : win + PTR_W'(1);
    end

    mem_net_buf #(
        .p_depth (p_buf_depth),
        .p_width (REQ_MSG_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .enq_val (accept),
        .enq_rdy (buf_rdy),
        .enq_msg (push_msg),
        .deq_val (mem_val),
        .deq_rdy (mem_rdy),
        .deq_msg (mem_msg)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter with three client ports.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int unsigned NP = 3;
    localparam int unsigned W  = REQ_MSG_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_val;
    logic [NP-1:0]     req_rdy;
    logic [NP*W-1:0]   req_msg;
    logic              mem_val;
    logic              mem_rdy;
    logic [W-1:0]      mem_msg;
    mem_net_req_msg_t  out_m;

    int checks   = 0;
    int failures = 0;

    assign out_m = mem_net_req_msg_t'(mem_msg);

    always #5 clk = ~clk;

    mem_req_arbiter #(.p_num_req(NP)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_val (req_val),
        .req_rdy (req_rdy),
        .req_msg (req_msg),
        .mem_val (mem_val),
        .mem_rdy (mem_rdy),
        .mem_msg (mem_msg)
    );

    // Origin field is deliberately junk (3) so stamping is visible.
    function automatic mem_net_req_msg_t port_msg(int unsigned i);
        mem_net_req_msg_t m;
        m.kind   = MEM_REQ_READ;
        m.opaque = 8'(8'h10 + i);
        m.origin = 2'd3;
        m.addr   = 32'h100 * (i + 1);
        m.len    = 2'd0;
        m.data   = 32'hA0 + i;
        return m;
    endfunction

    task automatic set_port_msgs();
        for (int unsigned i = 0; i < NP; i++)
            req_msg[i*W +: W] = port_msg(i);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req_val = '0; mem_rdy = 1'b0;
        set_port_msgs();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_val = '1; mem_rdy = 1'b1;
        set_port_msgs();
        @(negedge clk);
        checks++; if (mem_val !== 1'b0) begin failures++; $display("FAIL reset_mem_val got=%0b exp=0", mem_val); end
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL reset_rdy got=%b exp=000", req_rdy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_rdy !== 3'b001) begin failures++; $display("FAIL reset_first_grant got=%b exp=001", req_rdy); end
        checks++; if (mem_val !== 1'b0) begin failures++; $display("FAIL reset_no_early_val got=%0b exp=0", mem_val); end
        next_cycle();
        req_val = '0;
        @(negedge clk);
        checks++; if (mem_val !== 1'b1) begin failures++; $display("FAIL reset_latency_val got=%0b exp=1", mem_val); end
        checks++; if (out_m.origin !== 2'd0) begin failures++; $display("FAIL reset_latency_origin got=%0d exp=0", out_m.origin); end
        checks++; if (out_m.addr !== 32'h100) begin failures++; $display("FAIL reset_latency_addr got=%0h exp=100", out_m.addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_val !== 1'b0) begin failures++; $display("FAIL reset_drain got=%0b exp=0", mem_val); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_val = '1; mem_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (req_rdy !== 3'(1 << (k % 3))) begin
                failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_rdy, 3'(1 << (k % 3)));
            end
            if (k > 0) begin
                checks++; if (mem_val !== 1'b1) begin failures++; $display("FAIL rr_val k=%0d got=%0b exp=1", k, mem_val); end
                checks++;
                if (out_m.origin !== 2'((k - 1) % 3)) begin
                    failures++; $display("FAIL rr_origin k=%0d got=%0d exp=%0d", k, out_m.origin, (k - 1) % 3);
                end
                checks++;
                if (out_m.addr !== 32'h100 * 32'((k - 1) % 3 + 1)) begin
                    failures++; $display("FAIL rr_addr k=%0d got=%0h exp=%0h", k, out_m.addr, 32'h100 * ((k - 1) % 3 + 1));
                end
            end else begin
                checks++; if (mem_val !== 1'b0) begin failures++; $display("FAIL rr_first_val got=%0b exp=0", mem_val); end
            end
            next_cycle();
        end
        req_val = '0;
        next_cycle();
    endtask

    task automatic test_origin_stamp();
        mem_net_req_msg_t m_in;
        mem_net_req_msg_t exp;
        do_reset();
        m_in.kind = MEM_REQ_WRITE; m_in.opaque = 8'h5A; m_in.origin = 2'd0;
        m_in.addr = 32'h1000;      m_in.len = 2'd1;     m_in.data = 32'hDEADBEEF;
        req_msg[2*W +: W] = m_in;
        req_val = 3'b100; mem_rdy = 1'b1;
        @(negedge clk);
        checks++; if (req_rdy !== 3'b100) begin failures++; $display("FAIL origin_grant got=%b exp=100", req_rdy); end
        next_cycle();
        req_val = '0;
        exp = m_in;
        exp.origin = 2'd2;
        @(negedge clk);
        checks++; if (mem_val !== 1'b1) begin failures++; $display("FAIL origin_val got=%0b exp=1", mem_val); end
        checks++; if (out_m !== exp) begin failures++; $display("FAIL origin_msg got=%0h exp=%0h", out_m, exp); end
        next_cycle();
        set_port_msgs();
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_rdy [7] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
        logic       exp_val [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_org [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        do_reset();
        req_val = 3'b011; mem_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) mem_rdy = 1'b1;
            @(negedge clk);
            checks++; if (req_rdy !== exp_rdy[c]) begin failures++; $display("FAIL bp_rdy c=%0d got=%b exp=%b", c, req_rdy, exp_rdy[c]); end
            checks++; if (mem_val !== exp_val[c]) begin failures++; $display("FAIL bp_val c=%0d got=%0b exp=%0b", c, mem_val, exp_val[c]); end
            if (exp_val[c]) begin
                checks++; if (out_m.origin !== exp_org[c]) begin failures++; $display("FAIL bp_origin c=%0d got=%0d exp=%0d", c, out_m.origin, exp_org[c]); end
            end
            next_cycle();
        end
        req_val = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_sparse();
        do_reset();
        mem_rdy = 1'b1; req_val = 3'b001;
        @(negedge clk);
        checks++; if (req_rdy !== 3'b001) begin failures++; $display("FAIL sparse_first got=%b exp=001", req_rdy); end
        next_cycle();
        @(negedge clk);
        checks++; if (req_rdy !== 3'b001) begin failures++; $display("FAIL sparse_wrap got=%b exp=001", req_rdy); end
        next_cycle();
        req_val = 3'b011;
        @(negedge clk);
        checks++; if (req_rdy !== 3'b010) begin failures++; $display("FAIL sparse_rr got=%b exp=010", req_rdy); end
        next_cycle();
        req_val = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_rdy = 1'b0; req_val = 3'b011;
        next_cycle(); next_cycle();
        @(negedge clk);
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL mid_full_rdy got=%b exp=000", req_rdy); end
        checks++; if (mem_val !== 1'b1) begin failures++; $display("FAIL mid_full_val got=%0b exp=1", mem_val); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (mem_val !== 1'b0) begin failures++; $display("FAIL mid_async_val got=%0b exp=0", mem_val); end
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL mid_async_rdy got=%b exp=000", req_rdy); end
        req_val = '0;
        next_cycle(); next_cycle();
        rst = 1'b1; mem_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (mem_val !== 1'b0) begin failures++; $display("FAIL mid_discard c=%0d got=%0b exp=0", c, mem_val); end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b0; req_val = '0; mem_rdy = 1'b0; req_msg = '0;
        test_reset();
        test_round_robin();
        test_origin_stamp();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
